// File: rtl/ad79x8_slave.sv
// ad79x8_slave: SPI device side of an AD7908/7918/7928 ADC.
// It returns conversion frames and maintains the control register and the channel sequencer.
module ad79x8_slave #(
    parameter int DIGITS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              sclk,
    input  logic              din,
    output logic              dout,
    output logic              dout_oe,
    output logic [2:0]        ch_addr,
    input  logic [DIGITS-1:0] data_in,
    output logic [11:0]       ctrl_reg,
    output logic              ctrl_valid,
    output logic              frame_err
);
    localparam int PAD = 12 - DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cs_q, sclk_q;
    logic [1:0]  din_q;
    logic [15:0] tx_q, tx_d;
    logic [14:0] rx_q, rx_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [11:0] ctrl_q, ctrl_d;
    logic [2:0]  ch_q, ch_d;
    logic        valid_q, valid_d, err_q, err_d;
    logic [15:0] word;
    logic        cs_fall, cs_rise, sclk_fall;

    // Stage [2] lags the synchronized copy [1], so edges act one register after sync.
    assign cs_fall   = cs_q[2] & ~cs_q[1];
    assign cs_rise   = ~cs_q[2] & cs_q[1];
    assign sclk_fall = sclk_q[2] & ~sclk_q[1];
    assign word      = {rx_q, din_q[1]};

    assign dout       = (state_q == SHIFT) & tx_q[15];
    assign dout_oe    = state_q != IDLE;
    assign ch_addr    = ch_q;
    assign ctrl_reg   = ctrl_q;
    assign ctrl_valid = valid_q;
    assign frame_err  = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_q    <= '0;
            sclk_q  <= '0;
            din_q   <= '0;
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cs_q    <= {cs_q[1:0], cs};
            sclk_q  <= {sclk_q[1:0], sclk};
            din_q   <= {din_q[0], din};
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        ch_d    = ch_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (cs_fall) begin
                state_d = SHIFT;
                tx_d    = {1'b0, ch_q, 12'(data_in) << PAD};
                rx_d    = '0;
                cnt_d   = '0;
            end
            SHIFT: if (cs_rise) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end else if (sclk_fall) begin
                rx_d  = word[14:0];
                tx_d  = {tx_q[14:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    state_d = DONE;
                    if (word[15]) begin
                        ctrl_d  = word[15:4];
                        valid_d = 1'b1;
                        ch_d    = (word[14] & word[7]) ? 3'd0 : word[12:10];
                    end else if (ctrl_q[10] & ctrl_q[3]) begin
                        ch_d = (ch_q == ctrl_q[8:6]) ? 3'd0 : ch_q + 3'd1;
                    end
                end
            end
            DONE: if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ad79x8_slave.sv
// tb_ad79x8_slave: table-driven frames with a queue scoreboard, plus reset corner cases.
`timescale 1ns/1ps
module tb_ad79x8_slave;
    logic        clk = 1'b0, reset, cs, sclk, din, dout, dout_oe, ctrl_valid, frame_err;
    logic [2:0]  ch_addr;
    logic [7:0]  data_in;
    logic [11:0] ctrl_reg;
    int          checks = 0, errors = 0, cv_cnt = 0, fe_cnt = 0;

    typedef struct {
        logic [15:0] w;
        logic [7:0]  d;
        int          n;
        logic [15:0] fr;
        logic [11:0] ctrl;
        logic [2:0]  ch;
        int          cv;
        int          fe;
    } vec_t;

    vec_t tbl[10];
    vec_t q[$];

    always #5 clk = ~clk;

    ad79x8_slave #(.DIGITS(8)) dut (
        .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .din(din), .dout(dout),
        .dout_oe(dout_oe), .ch_addr(ch_addr), .data_in(data_in), .ctrl_reg(ctrl_reg),
        .ctrl_valid(ctrl_valid), .frame_err(frame_err)
    );

    always @(negedge clk) begin
        cv_cnt += int'(ctrl_valid);
        fe_cnt += int'(frame_err);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_frame(input logic [15:0] w, input int n, output logic [15:0] cap);
        cap = '0;
        @(negedge clk);
        cs = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            sclk = 1'b1;
            din  = (i < 16) ? w[15-i] : 1'b0;
            repeat (5) @(negedge clk);
            if (i < 16) cap[15-i] = dout;
            else check("dout_after_16", 32'(dout), 32'd0);
            if (i == 0) check("dout_oe_on", 32'(dout_oe), 32'd1);
            sclk = 1'b0;
            repeat (5) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
        check("dout_oe_off", 32'(dout_oe), 32'd0);
        check("dout_idle", 32'(dout), 32'd0);
    endtask

    initial begin
        logic [15:0] cap, mask, ones;
        int cv0, fe0, nb;
        vec_t e;
        ones = 16'hFFFF;
        reset = 1'b0; cs = 1'b1; sclk = 1'b0; din = 1'b0; data_in = '0;
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dout_oe", 32'(dout_oe), 32'd0);
        check("rst_ch_addr", 32'(ch_addr), 32'd0);
        check("rst_ctrl_reg", 32'(ctrl_reg), 32'd0);
        check("rst_ctrl_valid", 32'(ctrl_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        tbl[0] = '{16'h8F10, 8'hA5, 16, 16'h0A50, 12'h8F1, 3'd3, 1, 0};
        tbl[1] = '{16'h0000, 8'h3C, 16, 16'h33C0, 12'h8F1, 3'd3, 0, 0};
        tbl[2] = '{16'hCB80, 8'h11, 16, 16'h3110, 12'hCB8, 3'd0, 1, 0};
        tbl[3] = '{16'h0000, 8'h22, 16, 16'h0220, 12'hCB8, 3'd1, 0, 0};
        tbl[4] = '{16'h0000, 8'h33, 16, 16'h1330, 12'hCB8, 3'd2, 0, 0};
        tbl[5] = '{16'h0000, 8'h44, 16, 16'h2440, 12'hCB8, 3'd0, 0, 0};
        tbl[6] = '{16'h0000, 8'h55, 16, 16'h0550, 12'hCB8, 3'd1, 0, 0};
        tbl[7] = '{16'hFFFF, 8'h66, 9,  16'h1660, 12'hCB8, 3'd1, 0, 1};
        tbl[8] = '{16'h0000, 8'h77, 16, 16'h1770, 12'hCB8, 3'd2, 0, 0};
        tbl[9] = '{16'h8F10, 8'h88, 20, 16'h2880, 12'h8F1, 3'd3, 1, 0};

        for (int i = 0; i < 10; i++) begin
            data_in = tbl[i].d;
            q.push_back(tbl[i]);
            cv0 = cv_cnt;
            fe0 = fe_cnt;
            run_frame(tbl[i].w, tbl[i].n, cap);
            e    = q.pop_front();
            nb   = (e.n > 16) ? 16 : e.n;
            mask = ~(ones >> nb);
            check($sformatf("frame[%0d]", i), 32'(cap & mask), 32'(e.fr & mask));
            check($sformatf("ctrl_reg[%0d]", i), 32'(ctrl_reg), 32'(e.ctrl));
            check($sformatf("ch_addr[%0d]", i), 32'(ch_addr), 32'(e.ch));
            check($sformatf("ctrl_valid_count[%0d]", i), 32'(cv_cnt - cv0), 32'(e.cv));
            check($sformatf("frame_err_count[%0d]", i), 32'(fe_cnt - fe0), 32'(e.fe));
        end

        data_in = 8'hAB;
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        @(negedge clk);
        cs = 1'b0;
        repeat (6) @(negedge clk);
        ones = 16'hCB80;
        for (int i = 0; i < 7; i++) begin
            sclk = 1'b1;
            din  = ones[15-i];
            repeat (5) @(negedge clk);
            sclk = 1'b0;
            repeat (5) @(negedge clk);
        end
        sclk = 1'b1;
        din  = ones[8];
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_ctrl_reg", 32'(ctrl_reg), 32'd0);
        check("midrst_ch_addr", 32'(ch_addr), 32'd0);
        check("midrst_dout_oe", 32'(dout_oe), 32'd0);
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_ctrl_valid", 32'(ctrl_valid), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        @(negedge clk);
        sclk = 1'b0;
        cs   = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
        check("midrst_no_ctrl_valid", 32'(cv_cnt - cv0), 32'd0);
        data_in = 8'h99;
        run_frame(16'h0000, 16, cap);
        check("post_rst_frame", 32'(cap), 32'h0990);
        check("post_rst_ctrl_reg", 32'(ctrl_reg), 32'd0);
        check("post_rst_ch_addr", 32'(ch_addr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ad79x8_slave.md
# ad79x8_slave

Synthesizable SPI responder for the AD79X8 family (AD7908/7918/7928), the device end of the serial link driven by the ADC master. It receives the 16-bit control word on the master's data line, returns the conversion frame (leading zero, channel address, sample, zero padding), and maintains the control register and channel sequencer. It is used in the board-level testbench and as a drop-in ADC emulator on FPGA, with samples supplied by an external per-channel source.

## Interface
- DIGITS, 8, sample width (8 = AD7908, 10 = AD7918, 12 = AD7928)
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- cs  input  1  chip select from master, active-low, asynchronous to clk
- sclk  input  1  serial clock from master, idles low, asynchronous to clk
- din  input  1  serial control data from master, MSB first
- dout  output  1  serial conversion data to master, MSB first
- dout_oe  output  1  high while a frame is selected (synced cs low)
- ch_addr  output  3  channel whose sample is converted in the next frame
- data_in  input  DIGITS  sample for ch_addr, latched at frame start
- ctrl_reg  output  12  control register {WRITE,SEQ,DC,ADD[2:0],PM[1:0],SHADOW,DC,RANGE,CODING}
- ctrl_valid  output  1  one-clk pulse when ctrl_reg is loaded
- frame_err  output  1  one-clk pulse when a frame ends early

## Operation
- cs, sclk, din pass through 2-FF synchronizers; edges are detected on the synchronized copies.
- States: IDLE (cs high), SHIFT (cs low, counting sclk falls 0..16), DONE (16 falls seen, awaiting cs high).
- IDLE -> SHIFT on cs fall: tx shift reg <= {1'b0, ch_addr, data_in, (12-DIGITS) zeros}; bit counter <= 0; dout = tx[15].
- SHIFT, each sclk fall: rx <= {rx[14:0], din} (din sampled before tx update); tx shifts left, dout <= new tx[15]; counter increments.
- 16th fall -> DONE. Frame result, in the same cycle:
  - rx[15]=1 (WRITE): ctrl_reg <= rx[15:4]; ctrl_valid pulses; ch_addr <= 0 if SEQ=1 and SHADOW=1, else rx[12:10].
  - rx[15]=0 with ctrl_reg SEQ=1 and SHADOW=1: ch_addr <= (ch_addr == ADD) ? 0 : ch_addr+1.
  - Otherwise ctrl_reg and ch_addr are unchanged.
- DONE: further sclk falls are ignored; dout = 0. cs rise -> IDLE.
- cs rise while in SHIFT (fewer than 16 falls): frame_err pulses, ctrl_reg and ch_addr are unchanged, and the state goes to IDLE.
- cs fall and sclk fall detected in the same cycle: the frame is loaded and that sclk fall is ignored.
- dout = 0 whenever dout_oe = 0.
- Reset values: dout=0, dout_oe=0, ch_addr=0, ctrl_reg=12'h000, ctrl_valid=0, frame_err=0, state IDLE, counters and shift regs 0. Reset mid-frame aborts the frame with no frame_err.

## Timing
- Synchronizer latency: an external edge takes effect 3 clk after it occurs (2 sync stages + 1 register).
- dout_oe and the first dout bit (0) are valid 3 clk after cs falls. Each subsequent bit is valid 3 clk after the sclk fall.
- sclk high and low phases must each be at least 4 clk; cs setup to the first sclk rise must be at least 4 clk. Operation outside these limits is undefined.
- ctrl_reg, ch_addr and ctrl_valid update 3 clk after the 16th sclk fall.
- data_in must be stable from ch_addr change until 3 clk after the next cs fall.

## Test plan
- DIGITS=8, after reset, data_in=8'hA5, master sends 16'h8F10 -> dout frame 16'h0A50; ctrl_reg=12'h8F1; ctrl_valid pulses once; ch_addr=3.
- Follow-up frame with din=16'h0000, data_in=8'h3C -> dout frame 16'h33C0; ctrl_reg still 12'h8F1; ch_addr=3; no ctrl_valid.
- Send 16'hCB80 (SEQ=1, SHADOW=1, ADD=2), then four WRITE=0 frames -> frames report channels 0,1,2,0 in bits 14:12.
- cs rises after 9 sclk falls with din=16'hFFFF -> frame_err pulses once; ctrl_reg and ch_addr are unchanged; the next full frame works normally.
- 20 sclk falls within one cs-low frame -> only the first 16 count; dout=0 for falls 17..20; one ctrl_valid.
- reset asserted at bit 7 of a write frame -> all outputs at their reset values within 1 clk; ctrl_reg=0; a subsequent frame returns channel 0.
